mc_ctrl_fsm: RTL and testbench

- Multicycle control FSM for the MIPS core; replaces single-cycle main decoding with a sequenced controller.
- Drives the shared-memory, shared-ALU multicycle datapath: one memory port for fetch and data, one ALU for PC+4, branch target and execute.
- Handles a ready/request memory handshake so memory latency is variable.
- ALU function decode for R-type stays in the existing ALU decoder; this block emits the same 4-bit aluop encoding.

---
 rtl/mc_ctrl_pkg.sv | 68 ++++++
 rtl/mc_imm_opdec.sv | 60 ++++++
 rtl/mc_ctrl_fsm.sv | 188 ++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Brief    : Shared encodings for the multicycle MIPS controller: FSM states,
//            opcodes, aluop codes, ALU source B and PC source selects.
// Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        IMMEX   = 4'd8,
        IMMWB   = 4'd9,
        BRANCH  = 4'd10,
        JUMP    = 4'd11,
        TRAP    = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        CL_RTYPE   = 3'd0,
        CL_LOAD    = 3'd1,
        CL_STORE   = 3'd2,
        CL_BRANCH  = 3'd3,
        CL_JUMP    = 3'd4,
        CL_IMM     = 3'd5,
        CL_ILLEGAL = 3'd6
    } opclass_t;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_addiu = 6'b001001;
    localparam logic [5:0] c_op_slti  = 6'b001010;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_xori  = 6'b001110;
    localparam logic [5:0] c_op_lui   = 6'b001111;

    localparam logic [3:0] c_alu_add   = 4'b0000;
    localparam logic [3:0] c_alu_sub   = 4'b0001;
    localparam logic [3:0] c_alu_slt   = 4'b0010;
    localparam logic [3:0] c_alu_and   = 4'b0100;
    localparam logic [3:0] c_alu_or    = 4'b0101;
    localparam logic [3:0] c_alu_xor   = 4'b0110;
    localparam logic [3:0] c_alu_lui   = 4'b0111;
    localparam logic [3:0] c_alu_funct = 4'b1111;

    localparam logic [1:0] c_srcb_rt    = 2'b00;
    localparam logic [1:0] c_srcb_four  = 2'b01;
    localparam logic [1:0] c_srcb_imm   = 2'b10;
    localparam logic [1:0] c_srcb_immsh = 2'b11;

    localparam logic [1:0] c_pc_alu    = 2'b00;
    localparam logic [1:0] c_pc_aluout = 2'b01;
    localparam logic [1:0] c_pc_jump   = 2'b10;

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_imm_opdec.sv
`default_nettype none
// ============================================================================
// Module   : mc_imm_opdec
// Brief    : Combinational opcode decoder: class, legality, and the aluop /
//            zero-extend pair for immediate-format ALU instructions.
// Revision : 1.0 - initial release
// ============================================================================
module mc_imm_opdec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    output logic [3:0] aluop,
    output logic       zeroextend,
    output logic       legal,
    output opclass_t   opclass
);

    always_comb begin
        aluop      = c_alu_add;
        zeroextend = 1'b0;
        legal      = 1'b1;
        opclass    = CL_ILLEGAL;
        case (op)
            c_op_rtype: opclass = CL_RTYPE;
            c_op_lw:    opclass = CL_LOAD;
            c_op_sw:    opclass = CL_STORE;
            c_op_beq:   opclass = CL_BRANCH;
            c_op_j:     opclass = CL_JUMP;
            c_op_addi, c_op_addiu: opclass = CL_IMM;
            c_op_slti: begin
                opclass = CL_IMM;
                aluop   = c_alu_slt;
            end
            // Logical immediates and lui take an unsigned immediate
            c_op_andi: begin
                opclass    = CL_IMM;
                aluop      = c_alu_and;
                zeroextend = 1'b1;
            end
            c_op_ori: begin
                opclass    = CL_IMM;
                aluop      = c_alu_or;
                zeroextend = 1'b1;
            end
            c_op_xori: begin
                opclass    = CL_IMM;
                aluop      = c_alu_xor;
                zeroextend = 1'b1;
            end
            c_op_lui: begin
                opclass    = CL_IMM;
                aluop      = c_alu_lui;
                zeroextend = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule : mc_imm_opdec
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm
// Brief    : Multicycle MIPS control FSM with a req/ready memory handshake.
//            Optional performance counters enabled by MC_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter int         PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        op,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              memwrite,
    output logic              iord,
    output logic              irwrite,
    output logic              pcen,
    output logic [1:0]        pcsrc,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [3:0]        aluop,
    output logic              zeroextend,
    output logic              regdst,
    output logic              memtoreg,
    output logic              regwrite,
    output logic              illegal_op,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instr_cnt
);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_imm_aluop;
    logic       w_imm_zext;
    logic       w_legal;
    opclass_t   w_opclass;

    mc_imm_opdec u_opdec (
        .op        (op),
        .aluop     (w_imm_aluop),
        .zeroextend(w_imm_zext),
        .legal     (w_legal),
        .opclass   (w_opclass)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= state_t'(RESET_STATE);
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        pcsrc      = c_pc_alu;
        alusrca    = 1'b0;
        alusrcb    = c_srcb_rt;
        aluop      = c_alu_add;
        zeroextend = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        illegal_op = 1'b0;
        // Reset silences every output and discards a coincident mem_ready
        if (!reset) begin
            case (r_state)
                FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = c_srcb_four;
                    if (mem_ready) begin
                        irwrite = 1'b1;
                        pcen    = 1'b1;
                        w_next  = DECODE;
                    end
                end
                DECODE: begin
                    alusrcb = c_srcb_immsh;
                    if (!w_legal) w_next = TRAP;
                    else begin
                        case (w_opclass)
                            CL_RTYPE:             w_next = RTYPEEX;
                            CL_LOAD, CL_STORE:    w_next = MEMADR;
                            CL_BRANCH:            w_next = BRANCH;
                            CL_JUMP:              w_next = JUMP;
                            CL_IMM:               w_next = IMMEX;
                            default:              w_next = TRAP;
                        endcase
                    end
                end
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = c_srcb_imm;
                    w_next  = (w_opclass == CL_STORE) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) w_next = MEMWB;
                end
                MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                    w_next   = FETCH;
                end
                MEMWR: begin
                    mem_req  = 1'b1;
                    memwrite = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) w_next = FETCH;
                end
                RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop   = c_alu_funct;
                    w_next  = ALUWB;
                end
                ALUWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                    w_next   = FETCH;
                end
                IMMEX: begin
                    alusrca    = 1'b1;
                    alusrcb    = c_srcb_imm;
                    aluop      = w_imm_aluop;
                    zeroextend = w_imm_zext;
                    w_next     = IMMWB;
                end
                IMMWB: begin
                    regwrite = 1'b1;
                    w_next   = FETCH;
                end
                BRANCH: begin
                    alusrca = 1'b1;
                    aluop   = c_alu_sub;
                    pcsrc   = c_pc_aluout;
                    pcen    = zero;
                    w_next  = FETCH;
                end
                JUMP: begin
                    pcsrc  = c_pc_jump;
                    pcen   = 1'b1;
                    w_next = FETCH;
                end
                TRAP: illegal_op = 1'b1;
                default: w_next = FETCH;
            endcase
        end
    end

`ifdef MC_CTRL_PERF_EN
    localparam logic [PERF_W-1:0] c_perf_one = PERF_W'(1);

    logic              w_retire;
    logic [PERF_W-1:0] r_cycle_cnt;
    logic [PERF_W-1:0] r_instr_cnt;

    assign w_retire = (r_state == MEMWB) || (r_state == ALUWB) ||
                      (r_state == IMMWB) || (r_state == BRANCH) ||
                      (r_state == JUMP)  || ((r_state == MEMWR) && mem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + c_perf_one;
            if (w_retire) r_instr_cnt <= r_instr_cnt + c_perf_one;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule : mc_ctrl_fsm
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_fsm
// Brief    : Directed scoreboard bench for mc_ctrl_fsm control outputs and
//            counters (counter expectations follow MC_CTRL_PERF_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  op = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, memwrite, iord, irwrite, pcen;
    logic [1:0]  pcsrc, alusrcb;
    logic        alusrca;
    logic [3:0]  aluop;
    logic        zeroextend, regdst, memtoreg, regwrite, illegal_op;
    logic [31:0] cycle_cnt, instr_cnt;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.RESET_STATE(4'd0), .PERF_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .zeroextend(zeroextend), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .illegal_op(illegal_op),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    logic [18:0] w_obs;
    assign w_obs = {mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca,
                    alusrcb, aluop, zeroextend, regdst, memtoreg, regwrite,
                    illegal_op};

    typedef struct {
        logic [18:0] v;
        string       tag;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          m_instr = 0;
    logic [31:0] m_cyc;

    always @(posedge clk) begin
        if (reset) m_cyc <= 32'd0;
        else       m_cyc <= m_cyc + 32'd1;
    end

    function automatic logic [18:0] ov(
        input logic req, we, ird, irw, pce, input logic [1:0] psrc,
        input logic sa, input logic [1:0] sb, input logic [3:0] aop,
        input logic zx, rd, m2r, rw, ill);
        return {req, we, ird, irw, pce, psrc, sa, sb, aop, zx, rd, m2r, rw, ill};
    endfunction

    task automatic step(input logic rst, input logic rdy, input logic z,
                        input logic [18:0] expv, input string tag);
        exp_t e;
        reset = rst;
        mem_ready = rdy;
        zero = z;
        e.v = expv;
        e.tag = tag;
        q.push_back(e);
        @(negedge clk);
        e = q.pop_front();
        n_checks++;
        assert (w_obs === e.v) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", e.tag, w_obs, e.v);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        logic [31:0] ei, ec;
`ifdef MC_CTRL_PERF_EN
        ei = 32'(m_instr);
        ec = m_cyc;
`else
        ei = 32'd0;
        ec = 32'd0;
`endif
        n_checks++;
        assert (instr_cnt === ei) n_pass++;
        else $error("FAIL %s_instr observed=%0d expected=%0d", tag, instr_cnt, ei);
        n_checks++;
        assert (cycle_cnt === ec) n_pass++;
        else $error("FAIL %s_cycle observed=%0d expected=%0d", tag, cycle_cnt, ec);
    endtask

    initial begin
        logic [18:0] e_fw, e_fr, e_d, e_ma, e_mr, e_mwb, e_mw, e_rx, e_awb;
        logic [18:0] e_iwb, e_j, e_trap;
        logic [5:0]  imm_ops [7];
        logic [3:0]  imm_aop [7];
        logic        imm_zx  [7];

        e_fw   = ov(1,0,0,0,0,2'b00,0,2'b01,4'b0000,0,0,0,0,0);
        e_fr   = ov(1,0,0,1,1,2'b00,0,2'b01,4'b0000,0,0,0,0,0);
        e_d    = ov(0,0,0,0,0,2'b00,0,2'b11,4'b0000,0,0,0,0,0);
        e_ma   = ov(0,0,0,0,0,2'b00,1,2'b10,4'b0000,0,0,0,0,0);
        e_mr   = ov(1,0,1,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,0);
        e_mwb  = ov(0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0,1,1,0);
        e_mw   = ov(1,1,1,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,0);
        e_rx   = ov(0,0,0,0,0,2'b00,1,2'b00,4'b1111,0,0,0,0,0);
        e_awb  = ov(0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,1,0,1,0);
        e_iwb  = ov(0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,1,0);
        e_j    = ov(0,0,0,0,1,2'b10,0,2'b00,4'b0000,0,0,0,0,0);
        e_trap = ov(0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,1);

        imm_ops = '{6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b001111};
        imm_aop = '{4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
        imm_zx  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset with mem_ready high: all outputs silent
        step(1, 1, 0, 19'd0, "rst0");
        step(1, 0, 0, 19'd0, "rst1");
        chk_cnt("rst_cnt");

        // lw, zero-wait memory: 5 cycles
        op = 6'b100011;
        step(0, 1, 0, e_fr,  "lw_fetch");
        step(0, 1, 0, e_d,   "lw_decode");
        step(0, 0, 0, e_ma,  "lw_memadr");
        step(0, 1, 0, e_mr,  "lw_memrd");
        step(0, 0, 0, e_mwb, "lw_memwb");
        m_instr++;
        chk_cnt("lw_cnt");

        // sw with three wait cycles on the write
        op = 6'b101011;
        step(0, 1, 0, e_fr, "sw_fetch");
        step(0, 0, 0, e_d,  "sw_decode");
        step(0, 0, 0, e_ma, "sw_memadr");
        for (int i = 0; i < 3; i++) step(0, 0, 0, e_mw, "sw_wait");
        step(0, 1, 0, e_mw, "sw_done");
        m_instr++;
        chk_cnt("sw_cnt");

        // beq taken then not taken
        op = 6'b000100;
        step(0, 1, 0, e_fr, "beq1_fetch");
        step(0, 0, 0, e_d,  "beq1_decode");
        step(0, 0, 1, ov(0,0,0,0,1,2'b01,1,2'b00,4'b0001,0,0,0,0,0), "beq_taken");
        step(0, 1, 0, e_fr, "beq0_fetch");
        step(0, 0, 0, e_d,  "beq0_decode");
        step(0, 0, 0, ov(0,0,0,0,0,2'b01,1,2'b00,4'b0001,0,0,0,0,0), "beq_nottaken");
        m_instr += 2;

        // every immediate ALU opcode
        for (int i = 0; i < 7; i++) begin
            op = imm_ops[i];
            step(0, 1, 0, e_fr, "imm_fetch");
            step(0, 0, 0, e_d,  "imm_decode");
            step(0, 0, 0, ov(0,0,0,0,0,2'b00,1,2'b10,imm_aop[i],imm_zx[i],0,0,0,0), "imm_ex");
            step(0, 0, 0, e_iwb, "imm_wb");
            m_instr++;
        end
        chk_cnt("imm_cnt");

        // R-type with one fetch wait, then a jump
        op = 6'b000000;
        step(0, 0, 0, e_fw,  "r_fetchwait");
        step(0, 1, 0, e_fr,  "r_fetch");
        step(0, 0, 0, e_d,   "r_decode");
        step(0, 0, 0, e_rx,  "r_ex");
        step(0, 0, 0, e_awb, "r_wb");
        op = 6'b000010;
        step(0, 1, 0, e_fr, "j_fetch");
        step(0, 0, 0, e_d,  "j_decode");
        step(0, 0, 0, e_j,  "j_jump");
        m_instr += 2;
        chk_cnt("rj_cnt");

        // Reset lands in MEMRD together with mem_ready
        op = 6'b100011;
        step(0, 1, 0, e_fr, "rlw_fetch");
        step(0, 0, 0, e_d,  "rlw_decode");
        step(0, 0, 0, e_ma, "rlw_memadr");
        step(0, 0, 0, e_mr, "rlw_memrd_wait");
        step(1, 1, 0, 19'd0, "rlw_reset");
        m_instr = 0;
        step(0, 0, 0, e_fw, "rlw_refetch");
        chk_cnt("rlw_cnt");

        // Illegal opcode traps until reset
        op = 6'b111111;
        step(0, 1, 0, e_fr, "trap_fetch");
        step(0, 0, 0, e_d,  "trap_decode");
        for (int i = 0; i < 12; i++) step(0, logic'(i % 2), 0, e_trap, "trap_hold");
        step(1, 0, 0, 19'd0, "trap_reset");
        m_instr = 0;
        step(0, 0, 0, e_fw, "trap_refetch");
        chk_cnt("trap_cnt");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mc_ctrl_fsm
`default_nettype wire
